phase_sequencer: RTL
====================

# phase_sequencer

Generates the one-hot five-phase instruction cycle (F, R, X, M, W) that drives `program_counter` and the rest of the multi-cycle datapath. It stretches F and M with wait states until the instruction and data memories acknowledge, and keeps W to exactly one cycle per instruction so the PC advances once per instruction. It also handles run/halt control, memory-timeout detection and a retired-instruction counter.

## Interface
- `MEM_TIMEOUT`, default 255: maximum cycles F or M may wait for an ack before a bus error (legal range 2..65535).
- `clk` input 1: clock; all state changes on the rising edge.
- `n_rst` input 1: reset, synchronous, active-low.
- `run` input 1: start request; honoured only in IDLE or HALT.
- `halt_req` input 1: stop after the current instruction; sampled in W only.
- `imem_ack` input 1: instruction memory done; meaningful only while `imem_req`=1.
- `mem_op` input 1: current instruction is a load or store; sampled on the first M cycle.
- `dmem_ack` input 1: data memory done; meaningful only while `dmem_req`=1.
- `phase` output 5: one-hot, bit0=F … bit4=W; all zero in IDLE, HALT and ERR.
- `imem_req` output 1: high in every F cycle.
- `dmem_req` output 1: high in M cycles when the latched `mem_op`=1.
- `busy` output 1: high in F, R, X, M and W.
- `halted` output 1: high in HALT.
- `bus_err` output 1: high in ERR; sticky until reset.
- `err_phase` output 5: one-hot phase that timed out; valid when `bus_err`=1.
- `retired` output 32: count of completed W cycles; wraps modulo 2^32.

## Operation
- States: IDLE, F, R, X, M, W, HALT, ERR. Outputs are decoded from registered state only, so there are no comb paths from inputs to outputs.
- IDLE → F when `run`=1; otherwise stay.
- F → R on a cycle with `imem_ack`=1; otherwise stay.
- R → X unconditionally; X → M unconditionally.
- On M entry, `mem_op` is latched into `mem_pend`.
  - `mem_pend`=0: M lasts one cycle, then W.
  - `mem_pend`=1: stay in M until `dmem_ack`=1, then W.
- W → HALT if `halt_req`=1, else F. `retired` increments on every W cycle.
- HALT → F when `run`=1; `retired` holds.
- ERR: absorbing. Only `n_rst`=0 leaves it.
- Wait counter `wcnt` (16 bit):
  - cleared on entry to F or M;
  - increments each F cycle, or each M cycle with `mem_pend`=1, that has no ack.
  - If `wcnt`==`MEM_TIMEOUT`-1 and there is still no ack, go to ERR and record `err_phase` = current phase bit.
  - At most `MEM_TIMEOUT` cycles are ever spent in one F or M.
- Ack and timeout in the same cycle: ack wins and normal advance is taken.
- Acks arriving while the corresponding req=0 are ignored. `dmem_ack` during a non-memory M is ignored.
- `run` asserted while busy is ignored. `halt_req` outside W is ignored (not remembered).

## Timing
- Reset values: state=IDLE, `phase`=0, `imem_req`=0, `dmem_req`=0, `busy`=0, `halted`=0, `bus_err`=0, `err_phase`=0, `retired`=0, `wcnt`=0, `mem_pend`=0.
- Reset mid-instruction aborts immediately. The next cycle is IDLE with W never issued, so the PC is not advanced by the aborted instruction.
- Minimum instruction latency is 5 cycles: F (ack in first cycle), R, X, M (no mem op), W.
- Each F wait cycle and each memory M wait cycle adds 1 cycle.
- `run` sampled at edge t gives `phase`=F (bit0) in cycle t+1.
- W is always exactly one cycle. `retired` shows the new value in the cycle after W.
- Timeout: with no ack, F entered at cycle t gives ERR visible at cycle t+`MEM_TIMEOUT`.

## Test plan
- Reset, then `run` pulse, with `imem_ack` tied 1 and `mem_op`=0 → `phase` sequence 01,02,04,08,10,01,…; `retired` = 1 after the first W and 2 after 10 cycles.
- `imem_ack` delayed 3 cycles, `mem_op`=1 with `dmem_ack` delayed 2 cycles → F lasts 4 cycles and M lasts 3 cycles; `imem_req` and `dmem_req` are high exactly during those cycles; instruction takes 10 cycles.
- `halt_req`=1 during the 2nd W → HALT next cycle with `halted`=1, `phase`=0, `retired`=2; `run` pulse → F resumes. `halt_req` during X → no effect.
- `MEM_TIMEOUT`=4, `imem_ack`=0 → ERR 4 cycles after F entry with `bus_err`=1 and `err_phase`=01; `run` ignored; `n_rst` low clears everything. Repeat with ack arriving on the 4th cycle → R, not ERR.
- `n_rst`=0 asserted in M of an in-flight instruction → next cycle all outputs at reset values; no W pulse.
- `retired` preset near wrap (force to 32'hFFFF_FFFF) → after one W reads 0.

Source files
------------

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - one-hot F/R/X/M/W instruction-cycle sequencer
// Outputs decode registered state only; memory waits are bounded by MEM_TIMEOUT.
module phase_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        run,
  input  logic        halt_req,
  input  logic        imem_ack,
  input  logic        mem_op,
  input  logic        dmem_ack,
  output logic [4:0]  phase,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        busy,
  output logic        halted,
  output logic        bus_err,
  output logic [4:0]  err_phase,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_F,
    S_R,
    S_X,
    S_M,
    S_W,
    S_HALT,
    S_ERR
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic        mem_pend_q, mem_pend_d;
  logic [4:0]  err_phase_q, err_phase_d;
  logic        retire;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      wcnt_q      <= 16'd0;
      mem_pend_q  <= 1'b0;
      err_phase_q <= 5'd0;
      retired     <= 32'd0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      mem_pend_q  <= mem_pend_d;
      err_phase_q <= err_phase_d;
      if (retire) begin
        retired <= retired + 32'd1;
      end
    end
  end

  // Ack is tested before the timeout so an ack on the last allowed cycle still advances.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    mem_pend_d  = mem_pend_q;
    err_phase_d = err_phase_q;
    retire      = 1'b0;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (run) begin
          state_d = S_F;
          wcnt_d  = 16'd0;
        end
      end
      S_F: begin
        if (imem_ack) begin
          state_d = S_R;
        end else if (wcnt_q == WAIT_LAST) begin
          state_d     = S_ERR;
          err_phase_d = 5'b00001;
        end else begin
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      S_R: begin
        state_d = S_X;
      end
      S_X: begin
        state_d    = S_M;
        mem_pend_d = mem_op;
        wcnt_d     = 16'd0;
      end
      S_M: begin
        if (!mem_pend_q || dmem_ack) begin
          state_d = S_W;
        end else if (wcnt_q == WAIT_LAST) begin
          state_d     = S_ERR;
          err_phase_d = 5'b01000;
        end else begin
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      S_W: begin
        retire  = 1'b1;
        wcnt_d  = 16'd0;
        state_d = halt_req ? S_HALT : S_F;
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    phase = 5'd0;
    case (state_q)
      S_F:     phase = 5'b00001;
      S_R:     phase = 5'b00010;
      S_X:     phase = 5'b00100;
      S_M:     phase = 5'b01000;
      S_W:     phase = 5'b10000;
      default: phase = 5'd0;
    endcase
  end

  assign imem_req  = (state_q == S_F);
  assign dmem_req  = (state_q == S_M) && mem_pend_q;
  assign busy      = |phase;
  assign halted    = (state_q == S_HALT);
  assign bus_err   = (state_q == S_ERR);
  assign err_phase = err_phase_q;

endmodule
